// File: rtl/buffer_block_reader_pkg.sv
// Shared types and constants for PL masters reading PS-loaded BRAM buffers.
package buffer_block_reader_pkg;

    localparam int unsigned BUF_WORD_BYTES = 4;

    typedef logic [31:0] buf_word_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FLUSH
    } buffer_reader_state_t;

    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;

    // FIFO payload: stream word plus end-of-block marker
    typedef struct packed {
        logic      last;
        buf_word_t data;
    } stream_word_t;

endpackage

// File: rtl/t_buffer.sv
// BRAM port bundle between a buffer provider and a read-side consumer.
interface t_buffer;
    logic        en;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] dout;

    modport consumer (output en, output addr, output we, output din, input dout);
    modport provider (input en, input addr, input we, input din, output dout);
endinterface

// File: rtl/sync_fwft_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and clear.
module sync_fwft_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 33
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop_i && (cnt_q != '0);
    assign push_ok = push_i && ((cnt_q != CW'(DEPTH)) || pop_ok);
    assign data_o  = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_q <= rd_q + 1'b1;
            end
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/buffer_block_reader.sv
// Block reader: issues pipelined BRAM reads and streams the words out valid/ready.
module buffer_block_reader
    import buffer_block_reader_pkg::*;
#(
    parameter int unsigned BUF_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned MAX_WORDS   = 4096
) (
    input  ckrs_t             ClkRs_ix,
    t_buffer.consumer         buf_x,
    input  logic              start_i,
    input  logic [31:0]       base_addr_i,
    input  logic [15:0]       nwords_i,
    input  logic              abort_i,
    output logic [31:0]       data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned L  = BUF_LATENCY;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic clk;
    logic rst;
    assign clk = ClkRs_ix.clk;
    assign rst = ClkRs_ix.reset;

    buffer_reader_state_t state_q;
    buf_word_t            base_q;
    buf_word_t            addr_q;
    buf_word_t            addr_d;
    logic [15:0]          nwords_q;
    logic [15:0]          idx_q;
    logic [15:0]          ret_q;
    logic                 en_q;
    logic [L-1:0]         pipe_q;
    logic [2:0]           fcnt_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 err_q;

    logic [CW-1:0]        fifo_cnt;
    logic                 fifo_empty;
    logic                 fifo_push;
    logic                 fifo_pop;
    stream_word_t         fifo_in;
    stream_word_t         fifo_out;

    logic [3:0]           inflight;
    logic                 credit_ok;
    logic                 start_ok;
    logic                 issue;
    logic                 complete;
    logic                 go_flush;

    // Reads issued but not yet written into the FIFO
    always_comb begin
        inflight = 4'(en_q);
        for (int i = 0; i < int'(L); i++) begin
            inflight = inflight + 4'(pipe_q[i]);
        end
    end

    assign credit_ok = (32'(fifo_cnt) - 32'(fifo_pop) + 32'(inflight)) < FIFO_DEPTH;
    assign start_ok  = start_i && (nwords_i != 16'd0) && (32'(nwords_i) <= MAX_WORDS);
    assign complete  = (state_q == DRAIN) && fifo_pop && fifo_out.last;
    assign go_flush  = abort_i && !complete && ((state_q == ISSUE) || (state_q == DRAIN));

    always_comb begin
        issue = 1'b0;
        case (state_q)
            IDLE:    issue = start_ok;
            ISSUE:   issue = !abort_i && (idx_q != nwords_q) && credit_ok;
            default: issue = 1'b0;
        endcase
    end

    assign addr_d = (state_q == IDLE) ? (base_addr_i & ~32'h3)
                                      : base_q + 32'(idx_q) * BUF_WORD_BYTES;

    assign fifo_push    = pipe_q[L-1] && (state_q != FLUSH);
    assign fifo_pop     = valid_o && ready_i;
    assign fifo_in.last = (ret_q == nwords_q - 16'd1);
    assign fifo_in.data = buf_x.dout;

    sync_fwft_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (go_flush),
        .push_i  (fifo_push),
        .data_i  (fifo_in),
        .pop_i   (fifo_pop),
        .data_o  (fifo_out),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign valid_o = !fifo_empty;
    assign data_o  = fifo_out.data;
    assign last_o  = fifo_out.last && !fifo_empty;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign err_o   = err_q;

    assign buf_x.en   = en_q;
    assign buf_x.addr = addr_q;
    assign buf_x.we   = 4'b0000;
    assign buf_x.din  = 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            base_q   <= '0;
            addr_q   <= '0;
            nwords_q <= '0;
            idx_q    <= '0;
            ret_q    <= '0;
            en_q     <= 1'b0;
            pipe_q   <= '0;
            fcnt_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            en_q   <= issue;
            pipe_q <= (pipe_q << 1) | L'(en_q);
            if (issue) begin
                addr_q <= addr_d;
            end
            if (fifo_push) begin
                ret_q <= ret_q + 16'd1;
            end
            done_q <= 1'b0;
            err_q  <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (start_ok) begin
                            base_q   <= addr_d;
                            nwords_q <= nwords_i;
                            idx_q    <= 16'd1;
                            ret_q    <= 16'd0;
                            busy_q   <= 1'b1;
                            state_q  <= ISSUE;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (go_flush) begin
                        fcnt_q  <= '0;
                        state_q <= FLUSH;
                    end else begin
                        if (issue) begin
                            idx_q <= idx_q + 16'd1;
                        end
                        if (idx_q == nwords_q) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (complete) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (go_flush) begin
                        fcnt_q  <= '0;
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    // Count quiet cycles only once every outstanding read has landed
                    if (inflight != 4'd0) begin
                        fcnt_q <= '0;
                    end else if (fcnt_q == 3'(L - 1)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        fcnt_q <= fcnt_q + 3'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_block_reader.sv
// Directed bench for buffer_block_reader with a latency-accurate BRAM model.
module tb_buffer_block_reader;
    import buffer_block_reader_pkg::*;

    localparam int unsigned L = 2;

    logic        clk;
    logic        rst;
    ckrs_t       ckrs;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [15:0] nwords_i;
    logic        abort_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        last_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    t_buffer bus ();

    always_comb begin
        ckrs.clk   = clk;
        ckrs.reset = rst;
    end

    buffer_block_reader #(
        .BUF_LATENCY (L),
        .FIFO_DEPTH  (8),
        .MAX_WORDS   (4096)
    ) dut (
        .ClkRs_ix    (ckrs),
        .buf_x       (bus.consumer),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .nwords_i    (nwords_i),
        .abort_i     (abort_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .last_o      (last_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic buf_word_t mem_f(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h1234_5678;
    endfunction

    // BRAM: word for a read issued in cycle N appears on dout in cycle N+L
    buf_word_t rd_pipe [L];
    always @(posedge clk) begin
        rd_pipe[0] <= bus.en ? mem_f(bus.addr) : 32'hBAD0_BAD0;
        for (int i = 1; i < int'(L); i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.dout = rd_pipe[L-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int        s_cyc;
    logic [31:0] en_addr[$];
    int        en_cyc[$];
    logic [31:0] rx_data[$];
    logic      rx_last[$];
    int        rx_cyc[$];
    int        done_cyc[$];
    int        err_n, first_valid, busy_last, stall_viol, valid_after_abort, write_viol, max_fill;

    task automatic do_start(input logic [31:0] b, input logic [15:0] n, input logic r);
        @(negedge clk);
        base_addr_i = b; nwords_i = n; start_i = 1'b1; abort_i = 1'b0; ready_i = r;
        s_cyc = cyc;
        en_addr.delete(); en_cyc.delete(); rx_data.delete(); rx_last.delete();
        rx_cyc.delete(); done_cyc.delete();
        err_n = 0; first_valid = -1; busy_last = -1; stall_viol = 0;
        valid_after_abort = 0; write_viol = 0; max_fill = 0;
    endtask

    // rmode: 0 stall, 1 always ready, 2 toggle; abort_k/restart_k pulse inputs in cycle s_cyc+k
    task automatic run(input int ncyc, input int rmode, input int abort_k, input int restart_k);
        logic pv, pr, pl;
        logic [31:0] pd;
        pv = 1'b0; pr = 1'b1; pl = 1'b0; pd = '0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            start_i = (k == restart_k);
            abort_i = (k == abort_k);
            ready_i = (rmode == 1) || ((rmode == 2) && (k % 2 == 1));
            if (bus.en) begin en_addr.push_back(bus.addr); en_cyc.push_back(cyc); end
            if (valid_o && first_valid < 0) first_valid = cyc;
            if (valid_o && ready_i) begin
                rx_data.push_back(data_o); rx_last.push_back(last_o); rx_cyc.push_back(cyc);
            end
            if (pv && !pr && (!valid_o || data_o !== pd || last_o !== pl)) stall_viol++;
            if (abort_k > 0 && k > abort_k && valid_o) valid_after_abort++;
            if (done_o) done_cyc.push_back(cyc);
            if (err_o) err_n++;
            if (busy_o) busy_last = cyc;
            if (bus.we !== 4'b0 || bus.din !== 32'h0) write_viol++;
            if (int'(dut.fifo_cnt) > max_fill) max_fill = int'(dut.fifo_cnt);
            pv = valid_o; pr = ready_i; pd = data_o; pl = last_o;
        end
        start_i = 1'b0; abort_i = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({valid_o, busy_o, done_o, err_o, last_o, bus.en} !== 6'b0) begin
            errors++; $display("FAIL reset_outputs: got %b expected 000000", {valid_o, busy_o, done_o, err_o, last_o, bus.en});
        end
        checks++;
        if (bus.addr !== 32'h0 || data_o !== 32'h0) begin
            errors++; $display("FAIL reset_addr_data: addr %h data %h expected 0", bus.addr, data_o);
        end
    endtask

    task automatic test_basic();
        do_start(32'h100, 16'd4, 1'b1);
        run(20, 1, 0, 0);
        checks++;
        if (en_addr.size() !== 4) begin errors++; $display("FAIL basic_en_count: got %0d expected 4", en_addr.size()); end
        for (int i = 0; i < 4 && i < en_addr.size(); i++) begin
            checks++;
            if (en_addr[i] !== 32'h100 + 32'(4 * i) || en_cyc[i] !== s_cyc + 1 + i) begin
                errors++; $display("FAIL basic_issue%0d: addr %h cyc %0d expected %h cyc %0d", i, en_addr[i], en_cyc[i], 32'h100 + 32'(4 * i), s_cyc + 1 + i);
            end
        end
        checks++;
        if (first_valid !== s_cyc + 4) begin errors++; $display("FAIL basic_first_valid: got %0d expected %0d", first_valid, s_cyc + 4); end
        checks++;
        if (rx_data.size() !== 4) begin errors++; $display("FAIL basic_rx_count: got %0d expected 4", rx_data.size()); end
        for (int i = 0; i < 4 && i < rx_data.size(); i++) begin
            checks++;
            if (rx_data[i] !== mem_f(32'h100 + 32'(4 * i)) || rx_last[i] !== (i == 3)) begin
                errors++; $display("FAIL basic_word%0d: got %h/%b expected %h/%b", i, rx_data[i], rx_last[i], mem_f(32'h100 + 32'(4 * i)), i == 3);
            end
        end
        checks++;
        if (done_cyc.size() !== 1 || rx_cyc.size() !== 4 || done_cyc[0] !== rx_cyc[3] + 1) begin
            errors++; $display("FAIL basic_done: %0d pulses, first at %0d expected one at %0d", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1, s_cyc + 8);
        end
        checks++;
        if (busy_last !== s_cyc + 7) begin errors++; $display("FAIL basic_busy_last: got %0d expected %0d", busy_last, s_cyc + 7); end
        checks++;
        if (write_viol !== 0) begin errors++; $display("FAIL basic_no_write: got %0d expected 0", write_viol); end
    endtask

    task automatic test_backpressure();
        do_start(32'h0000_0200, 16'd16, 1'b1);
        run(80, 2, 0, 6);
        checks++;
        if (rx_data.size() !== 16 || en_addr.size() !== 16) begin
            errors++; $display("FAIL bp_counts: rx %0d en %0d expected 16 16", rx_data.size(), en_addr.size());
        end
        for (int i = 0; i < 16 && i < rx_data.size(); i++) begin
            checks++;
            if (rx_data[i] !== mem_f(32'h200 + 32'(4 * i)) || rx_last[i] !== (i == 15)) begin
                errors++; $display("FAIL bp_word%0d: got %h/%b expected %h/%b", i, rx_data[i], rx_last[i], mem_f(32'h200 + 32'(4 * i)), i == 15);
            end
        end
        checks++;
        if (stall_viol !== 0) begin errors++; $display("FAIL bp_stall_stable: got %0d expected 0", stall_viol); end
        checks++;
        if (max_fill > 8) begin errors++; $display("FAIL bp_fill: got %0d expected <= 8", max_fill); end
        checks++;
        if (err_n !== 0 || done_cyc.size() !== 1) begin
            errors++; $display("FAIL bp_busy_start: err %0d done %0d expected 0 1", err_n, done_cyc.size());
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [3];
        exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0000_0000;
        do_start(32'hFFFF_FFF8, 16'd3, 1'b1);
        run(20, 1, 0, 0);
        checks++;
        if (en_addr.size() !== 3 || rx_data.size() !== 3) begin
            errors++; $display("FAIL wrap_counts: en %0d rx %0d expected 3 3", en_addr.size(), rx_data.size());
        end
        for (int i = 0; i < 3 && i < en_addr.size() && i < rx_data.size(); i++) begin
            checks++;
            if (en_addr[i] !== exp_a[i] || rx_data[i] !== mem_f(exp_a[i])) begin
                errors++; $display("FAIL wrap_addr%0d: got %h/%h expected %h/%h", i, en_addr[i], rx_data[i], exp_a[i], mem_f(exp_a[i]));
            end
        end
    endtask

    task automatic test_reject();
        logic [15:0] bad [2];
        bad[0] = 16'd0; bad[1] = 16'd4097;
        for (int j = 0; j < 2; j++) begin
            do_start(32'h100, bad[j], 1'b1);
            run(8, 1, 0, 0);
            checks++;
            if (err_n !== 1 || en_addr.size() !== 0 || busy_last !== -1 || done_cyc.size() !== 0) begin
                errors++; $display("FAIL reject_n%0d: err %0d en %0d busy_last %0d done %0d expected 1 0 -1 0", bad[j], err_n, en_addr.size(), busy_last, done_cyc.size());
            end
        end
    endtask

    task automatic test_single();
        do_start(32'h0000_0042, 16'd1, 1'b1);
        run(12, 1, 0, 0);
        checks++;
        if (en_addr.size() !== 1 || rx_data.size() !== 1) begin
            errors++; $display("FAIL single_counts: en %0d rx %0d expected 1 1", en_addr.size(), rx_data.size());
        end else begin
            checks++;
            if (en_addr[0] !== 32'h40 || rx_data[0] !== mem_f(32'h40) || rx_last[0] !== 1'b1) begin
                errors++; $display("FAIL single_word: got %h/%h/%b expected 00000040/%h/1", en_addr[0], rx_data[0], rx_last[0], mem_f(32'h40));
            end
        end
        checks++;
        if (first_valid !== s_cyc + 4 || done_cyc.size() !== 1 || done_cyc[0] !== s_cyc + 5) begin
            errors++; $display("FAIL single_timing: valid %0d done %0d expected %0d %0d", first_valid, done_cyc.size() > 0 ? done_cyc[0] : -1, s_cyc + 4, s_cyc + 5);
        end
    endtask

    task automatic test_abort();
        do_start(32'h0000_8000, 16'd64, 1'b0);
        run(20, 0, 5, 0);
        checks++;
        if (en_cyc.size() === 0 || en_cyc[en_cyc.size() - 1] > s_cyc + 5) begin
            errors++; $display("FAIL abort_en_drop: last en %0d expected <= %0d", en_cyc.size() > 0 ? en_cyc[en_cyc.size() - 1] : -1, s_cyc + 5);
        end
        checks++;
        if (valid_after_abort !== 0 || rx_data.size() !== 0) begin
            errors++; $display("FAIL abort_valid: got %0d cycles expected 0", valid_after_abort);
        end
        checks++;
        if (done_cyc.size() !== 1 || done_cyc[0] !== s_cyc + 10 || busy_last !== s_cyc + 9) begin
            errors++; $display("FAIL abort_done: %0d pulses at %0d busy_last %0d expected one at %0d busy_last %0d", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1, busy_last, s_cyc + 10, s_cyc + 9);
        end
        do_start(32'h0000_2000, 16'd2, 1'b1);
        run(15, 1, 0, 0);
        checks++;
        if (rx_data.size() !== 2 || rx_data[0] !== mem_f(32'h2000) || rx_data[1] !== mem_f(32'h2004) || rx_last[1] !== 1'b1 || rx_last[0] !== 1'b0) begin
            errors++; $display("FAIL abort_restart: got %0d words first %h expected 2 words first %h", rx_data.size(), rx_data.size() > 0 ? rx_data[0] : 32'h0, mem_f(32'h2000));
        end
    endtask

    task automatic test_abort_on_last();
        do_start(32'h0000_0300, 16'd2, 1'b1);
        run(15, 1, 5, 0);
        checks++;
        if (rx_data.size() !== 2 || rx_cyc[1] !== s_cyc + 5 || rx_last[1] !== 1'b1) begin
            errors++; $display("FAIL abort_last_rx: got %0d words expected 2 with last at %0d", rx_data.size(), s_cyc + 5);
        end
        checks++;
        if (done_cyc.size() !== 1 || done_cyc[0] !== s_cyc + 6) begin
            errors++; $display("FAIL abort_last_done: %0d pulses at %0d expected one at %0d", done_cyc.size(), done_cyc.size() > 0 ? done_cyc[0] : -1, s_cyc + 6);
        end
    endtask

    task automatic test_reset_mid();
        do_start(32'h0000_5000, 16'd64, 1'b0);
        run(3, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.en, busy_o, valid_o, done_o, err_o, last_o} !== 6'b0 || bus.addr !== 32'h0 || data_o !== 32'h0) begin
            errors++; $display("FAIL reset_mid_async: en/busy/valid/done/err/last %b addr %h data %h expected 0", {bus.en, busy_o, valid_o, done_o, err_o, last_o}, bus.addr, data_o);
        end
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        do_start(32'h0000_3000, 16'd2, 1'b1);
        run(15, 1, 0, 0);
        checks++;
        if (rx_data.size() !== 2 || rx_data[0] !== mem_f(32'h3000) || rx_data[1] !== mem_f(32'h3004) || done_cyc.size() !== 1) begin
            errors++; $display("FAIL reset_mid_restart: got %0d words %0d done expected 2 words 1 done", rx_data.size(), done_cyc.size());
        end
    endtask

    task automatic test_max_words();
        int bad;
        bad = 0;
        do_start(32'h4000_0000, 16'd4096, 1'b1);
        run(4130, 1, 0, 0);
        checks++;
        if (rx_data.size() !== 4096 || done_cyc.size() !== 1) begin
            errors++; $display("FAIL max_counts: rx %0d done %0d expected 4096 1", rx_data.size(), done_cyc.size());
        end
        for (int i = 0; i < rx_data.size(); i++) begin
            if (rx_data[i] !== mem_f(32'h4000_0000 + 32'(4 * i)) || rx_last[i] !== (i == 4095)) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL max_words_data: got %0d bad words expected 0", bad); end
        checks++;
        if (en_addr.size() !== 4096 || en_addr[4095] !== 32'h4000_3FFC) begin
            errors++; $display("FAIL max_last_addr: got %0d issues expected 4096 ending 40003ffc", en_addr.size());
        end
    endtask

    initial begin
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; ready_i = 1'b0;
        base_addr_i = '0; nwords_i = '0;
        @(negedge clk);
        test_reset();
        @(negedge clk) rst = 1'b0;
        test_basic();
        test_backpressure();
        test_wrap();
        test_reject();
        test_single();
        test_abort();
        test_abort_on_last();
        test_reset_mid();
        test_max_words();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
